amo_core_arbiter: RTL
=====================

AMO_CORE_ARBITER -- requirements
Module: amo_core_arbiter

Interface
REQ-001 SHALL have parameters: CORE_NUMS, default `CORE_NUMS, number of requesting cores; CORE_NUMS_BITS, default 2, core index width; XLEN, default 32, address/data width; LOCK_CYCLES, default 64, LR-lock timeout.
REQ-002 SHALL have ports, one per line: clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous and active-high.
REQ-004 core_strobe_i  in  CORE_NUMS  per-core request pulse.
REQ-005 core_addr_i  in  CORE_NUMS*XLEN, core_rw_i  in  CORE_NUMS, core_data_i  in  CORE_NUMS*XLEN, core_is_amo_i  in  CORE_NUMS, core_amo_type_i  in  CORE_NUMS*5: per-core request fields, packed with core 0 in the LSBs.
REQ-006 core_done_o  out  CORE_NUMS  one-hot completion pulse; core_data_o  out  XLEN  read data broadcast to all cores.
REQ-007 au_core_id_o  out  CORE_NUMS_BITS, au_strobe_o  out  1, au_addr_o  out  XLEN, au_rw_o  out  1, au_data_o  out  XLEN, au_is_amo_o  out  1, au_amo_type_o  out  5: single request port to the downstream atomic unit.
REQ-008 au_done_i  in  1, au_data_i  in  XLEN: completion and read data from the atomic unit.

Function
REQ-009 SHALL set pending[k] on core_strobe_i[k] and clear it on core_done_o[k]; a strobe from a core already pending SHALL be ignored.
REQ-010 Eligible set = pending | core_strobe_i; in IDLE SHALL grant the first eligible core at or after rr_ptr, wrapping modulo CORE_NUMS.
REQ-011 SHALL use FSM states IDLE, ISSUE and WAIT, plus LOCK when enabled: IDLE->ISSUE on a grant; ISSUE->WAIT after exactly one cycle; WAIT->IDLE on au_done_i.
REQ-012 On grant, SHALL register the granted core's fields and index into the au_* outputs and hold them stable until that transaction's done.
REQ-013 SHALL assert au_strobe_o for exactly one cycle, in ISSUE; latency is strobe at T -> au_strobe_o at T+1 when idle.
REQ-014 SHALL pass completion combinationally: core_done_o[g] = au_done_i while in ISSUE or WAIT; core_data_o = au_data_i.
REQ-015 au_done_i in ISSUE SHALL complete the transaction and go to IDLE; au_done_i in IDLE SHALL be ignored.
REQ-016 On completion, rr_ptr SHALL become (g+1) mod CORE_NUMS; the next grant is no earlier than the cycle after done.
REQ-017 Simultaneous strobes SHALL all be recorded pending and served in round-robin order with no loss.
REQ-018 Cores hold their fields stable from strobe until done; the arbiter SHALL NOT re-sample fields after grant.

Reset
REQ-019 Asynchronous rst_i SHALL clear state to IDLE, pending to 0, rr_ptr to 0, the lock counter to 0, au_strobe_o to 0, core_done_o to 0, and all registered au_* fields to 0.
REQ-020 Reset mid-transaction SHALL drop the in-flight request without asserting done; the atomic unit shares the reset.

Configuration
REQ-021 With macro AMO_LR_LOCK_EN defined: after a completed LR (is_amo, type[1:0]=2'b10) from core g, SHALL enter LOCK, in which only core g is eligible.
REQ-022 LOCK SHALL exit to round-robin when a non-LR transaction from g completes, or when the lock counter reaches LOCK_CYCLES; the counter counts LOCK cycles with g not pending.
REQ-023 Without AMO_LR_LOCK_EN: no LOCK state and no counter; pure round-robin.

Structure
REQ-024 CORE_NUMS and the AMO type encodings (LR=5'b00010, SC=5'b00011) SHALL live in the shared aquila_config package/header.
REQ-025 SHALL instantiate one combinational sub-module, rr_priority_picker (request vector + pointer -> one-hot grant + index).

Verification (CORE_NUMS=4, XLEN=32)
REQ-026 Single request: core 2 strobes AMOADD addr 0x100 at T -> au_strobe_o=1 and au_core_id_o=2 at T+1; au_done_i with data 0x5 -> core_done_o=4'b0100, core_data_o=0x5.
REQ-027 Simultaneous: cores 0,1,3 strobe same cycle, rr_ptr=0 -> grants 0,1,3 in order, each done one-hot, rr_ptr ends at 0.
REQ-028 Fairness wrap: rr_ptr=3, cores 0 and 3 pending -> core 3 granted first, then core 0.
REQ-029 Reset mid-op: assert rst_i in WAIT -> au_strobe_o=0, core_done_o=0, pending=0 immediately; a later au_done_i produces no core_done_o.
REQ-030 AMO_LR_LOCK_EN: core 1 LR 0x200 completes, core 0 strobes -> core 0 is not granted until core 1's SC completes, or until 64 idle LOCK cycles elapse.
REQ-031 Duplicate strobe from a pending core 2 -> exactly one au_strobe_o and one core_done_o[2].

Source files
------------

// File: rtl/aquila_config_pkg.sv
// Shared aquila configuration: core count, AMO type encodings and arbiter states.
// The LOCK state exists only when AMO_LR_LOCK_EN is defined.
package aquila_config;

  localparam int CORE_NUMS = 4;

  localparam logic [4:0] AMO_TYPE_LR = 5'b00010;
  localparam logic [4:0] AMO_TYPE_SC = 5'b00011;

`ifdef AMO_LR_LOCK_EN
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LOCK} arb_state_e;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_e;
`endif

  // Only the low two type bits tell LR apart from the other AMO encodings.
  function automatic logic is_lr(input logic is_amo, input logic [4:0] amo_type);
    return is_amo && (amo_type[1:0] == AMO_TYPE_LR[1:0]);
  endfunction

endpackage

// File: rtl/amo_core_arbiter_picker.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping modulo N.
module rr_priority_picker #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IDXW-1:0] idx_o
);

  logic [IDXW-1:0] k;
  logic            found;

  // NOTE: every output and temporary gets a default first so no latch is inferred.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    k       = '0;
    for (int i = 0; i < N; i++) begin
      k = IDXW'((int'(ptr_i) + i) % N);
      if (!found && req_i[k]) begin
        found      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = k;
      end
    end
  end

endmodule

// File: rtl/amo_core_arbiter.sv
// Round-robin arbiter funnelling per-core AMO requests into a single atomic unit.
// Define AMO_LR_LOCK_EN to hold the grant on a core after its LR until SC or timeout.
module amo_core_arbiter
  import aquila_config::*;
#(
  parameter int CORE_NUMS      = aquila_config::CORE_NUMS,
  parameter int CORE_NUMS_BITS = 2,
  parameter int XLEN           = 32,
  parameter int LOCK_CYCLES    = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CORE_NUMS-1:0]      core_strobe_i,
  input  logic [CORE_NUMS*XLEN-1:0] core_addr_i,
  input  logic [CORE_NUMS-1:0]      core_rw_i,
  input  logic [CORE_NUMS*XLEN-1:0] core_data_i,
  input  logic [CORE_NUMS-1:0]      core_is_amo_i,
  input  logic [CORE_NUMS*5-1:0]    core_amo_type_i,
  output logic [CORE_NUMS-1:0]      core_done_o,
  output logic [XLEN-1:0]           core_data_o,
  output logic [CORE_NUMS_BITS-1:0] au_core_id_o,
  output logic                      au_strobe_o,
  output logic [XLEN-1:0]           au_addr_o,
  output logic                      au_rw_o,
  output logic [XLEN-1:0]           au_data_o,
  output logic                      au_is_amo_o,
  output logic [4:0]                au_amo_type_o,
  input  logic                      au_done_i,
  input  logic [XLEN-1:0]           au_data_i
);

  if (LOCK_CYCLES < 1 || CORE_NUMS_BITS < $clog2(CORE_NUMS)) begin : g_param_check
    $error("amo_core_arbiter: LOCK_CYCLES must be >= 1 and CORE_NUMS_BITS wide enough");
  end

  arb_state_e                state_q, state_d;
  logic [CORE_NUMS-1:0]      pending_q, pending_d;
  logic [CORE_NUMS_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic                      au_strobe_q, au_strobe_d;
  logic [CORE_NUMS_BITS-1:0] au_core_id_q, au_core_id_d;
  logic [XLEN-1:0]           au_addr_q, au_addr_d;
  logic                      au_rw_q, au_rw_d;
  logic [XLEN-1:0]           au_data_q, au_data_d;
  logic                      au_is_amo_q, au_is_amo_d;
  logic [4:0]                au_amo_type_q, au_amo_type_d;

  logic [CORE_NUMS-1:0]      eligible, pick_req, pick_grant, done_vec;
  logic [CORE_NUMS_BITS-1:0] pick_idx;
  logic                      pick_valid, busy;

`ifdef AMO_LR_LOCK_EN
  localparam int LockCntW = $clog2(LOCK_CYCLES + 1);
  logic [LockCntW-1:0] lock_cnt_q, lock_cnt_d;
`endif

  rr_priority_picker #(
    .N    (CORE_NUMS),
    .IDXW (CORE_NUMS_BITS)
  ) u_picker (
    .req_i   (pick_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  assign pick_valid = |pick_grant;

  always_comb begin
    eligible = pending_q | core_strobe_i;
    busy     = (state_q == ISSUE) || (state_q == WAIT);
    done_vec = '0;
    if (busy && au_done_i) done_vec[au_core_id_q] = 1'b1;
`ifdef AMO_LR_LOCK_EN
    // While locked the held au_core_id_q still names the LR owner.
    pick_req = (state_q == LOCK) ? (eligible & (CORE_NUMS'(1) << au_core_id_q)) : eligible;
`else
    pick_req = eligible;
`endif
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = eligible & ~done_vec;
    rr_ptr_d      = rr_ptr_q;
    au_strobe_d   = 1'b0;
    au_core_id_d  = au_core_id_q;
    au_addr_d     = au_addr_q;
    au_rw_d       = au_rw_q;
    au_data_d     = au_data_q;
    au_is_amo_d   = au_is_amo_q;
    au_amo_type_d = au_amo_type_q;
`ifdef AMO_LR_LOCK_EN
    lock_cnt_d    = lock_cnt_q;
`endif

    if ((state_q == IDLE
`ifdef AMO_LR_LOCK_EN
         || state_q == LOCK
`endif
        ) && pick_valid) begin
      state_d       = ISSUE;
      au_strobe_d   = 1'b1;
      au_core_id_d  = pick_idx;
      au_addr_d     = core_addr_i[int'(pick_idx)*XLEN +: XLEN];
      au_rw_d       = core_rw_i[pick_idx];
      au_data_d     = core_data_i[int'(pick_idx)*XLEN +: XLEN];
      au_is_amo_d   = core_is_amo_i[pick_idx];
      au_amo_type_d = core_amo_type_i[int'(pick_idx)*5 +: 5];
    end else if (busy && au_done_i) begin
      rr_ptr_d = CORE_NUMS_BITS'((int'(au_core_id_q) + 1) % CORE_NUMS);
      state_d  = IDLE;
`ifdef AMO_LR_LOCK_EN
      lock_cnt_d = '0;
      if (is_lr(au_is_amo_q, au_amo_type_q)) state_d = LOCK;
`endif
    end else if (state_q == ISSUE) begin
      state_d = WAIT;
`ifdef AMO_LR_LOCK_EN
    end else if (state_q == LOCK) begin
      // Owner not requesting this cycle: age the lock, release after LOCK_CYCLES.
      if (lock_cnt_q == LockCntW'(LOCK_CYCLES - 1)) begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end else begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      au_strobe_q   <= 1'b0;
      au_core_id_q  <= '0;
      au_addr_q     <= '0;
      au_rw_q       <= 1'b0;
      au_data_q     <= '0;
      au_is_amo_q   <= 1'b0;
      au_amo_type_q <= '0;
`ifdef AMO_LR_LOCK_EN
      lock_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      au_strobe_q   <= au_strobe_d;
      au_core_id_q  <= au_core_id_d;
      au_addr_q     <= au_addr_d;
      au_rw_q       <= au_rw_d;
      au_data_q     <= au_data_d;
      au_is_amo_q   <= au_is_amo_d;
      au_amo_type_q <= au_amo_type_d;
`ifdef AMO_LR_LOCK_EN
      lock_cnt_q    <= lock_cnt_d;
`endif
    end
  end

  assign core_done_o   = done_vec;
  assign core_data_o   = au_data_i;
  assign au_strobe_o   = au_strobe_q;
  assign au_core_id_o  = au_core_id_q;
  assign au_addr_o     = au_addr_q;
  assign au_rw_o       = au_rw_q;
  assign au_data_o     = au_data_q;
  assign au_is_amo_o   = au_is_amo_q;
  assign au_amo_type_o = au_amo_type_q;

endmodule
